// File: rtl/online_mult_seq.sv
// online_mult_seq
//
// Sequencer for a parallel online (MSD-first, radix-2 signed-digit)
// multiplier array. It latches two N-digit operands and clears the array
// residual. It then streams one x and one y digit per step, MSD first, for
// N+DELTA steps. The product digits selected by the datapath are collected
// into a one-entry valid/ready output buffer.
//
// Digit encoding is {p,n} with value p-n. The code 2'b11 is redundant and
// is normalised to 2'b00 when the operands are latched.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           begin a multiplication (honoured only in IDLE)
//   abort           synchronous abort, back to IDLE on the next edge
//   x_in, y_in      operands, digit i at [2i+1:2i], digit N-1 is the MSD
//   busy            state != IDLE
//   arr_clr         clear the array residual (one cycle, in CLR)
//   arr_en          the array advances one step this cycle
//   x_dig, y_dig    current operand digits presented to the array
//   sel_dig         product digit selected by the datapath for this step
//   z_dig, z_valid, z_ready, z_last
//                   output digit buffer and its handshake; z_last marks
//                   the N-th (least significant) product digit
//   done            one-cycle completion pulse
module online_mult_seq #(
  parameter int N     = 8,
  parameter int DELTA = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [2*N-1:0] x_in,
  input  logic [2*N-1:0] y_in,
  output logic           busy,
  output logic           arr_clr,
  output logic           arr_en,
  output logic [1:0]     x_dig,
  output logic [1:0]     y_dig,
  input  logic [1:0]     sel_dig,
  output logic [1:0]     z_dig,
  output logic           z_valid,
  input  logic           z_ready,
  output logic           z_last,
  output logic           done
);

  // k runs 0 .. N+DELTA, so it needs room for N+DELTA itself.
  localparam int KW = $clog2(N + DELTA + 1);
  // The output counter runs 0 .. N.
  localparam int CW = $clog2(N + 1);

  localparam logic [KW-1:0] K_FIRST = KW'(DELTA);
  localparam logic [KW-1:0] K_LAST  = KW'(N + DELTA - 1);
  localparam logic [CW-1:0] CNT_ALL = CW'(N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Replace the redundant zero code 2'b11 by the canonical 2'b00.
  function automatic logic [2*N-1:0] norm_digits(input logic [2*N-1:0] v);
    logic [2*N-1:0] r;
    r = v;
    for (int i = 0; i < N; i++) begin
      if (v[2*i +: 2] == 2'b11) begin
        r[2*i +: 2] = 2'b00;
      end else begin
        r[2*i +: 2] = v[2*i +: 2];
      end
    end
    return r;
  endfunction

  state_t          state_r;
  state_t          next_s;
  logic [2*N-1:0]  x_sr_r;
  logic [2*N-1:0]  y_sr_r;
  logic [KW-1:0]   k_r;
  logic [CW-1:0]   out_cnt_r;
  logic [1:0]      z_dig_r;
  logic            z_valid_r;
  logic            z_last_r;

  logic            stall_s;
  logic            step_s;
  logic            capture_s;
  logic            last_step_s;
  logic            pop_s;

  // Step qualification. A full buffer that is not being drained blocks
  // the array, because the next capture would have nowhere to go.
  always_comb begin
    stall_s     = z_valid_r && !z_ready;
    step_s      = (state_r == RUN) && !stall_s;
    capture_s   = step_s && (k_r >= K_FIRST);
    last_step_s = step_s && (k_r == K_LAST);
    pop_s       = z_valid_r && z_ready;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s = CLR;
        end else begin
          next_s = IDLE;
        end
      end
      CLR: begin
        next_s = RUN;
      end
      RUN: begin
        if (last_step_s) begin
          next_s = DRAIN;
        end else begin
          next_s = RUN;
        end
      end
      DRAIN: begin
        // All N digits captured; leave once the last one has been taken.
        if ((out_cnt_r == CNT_ALL) && (pop_s || !z_valid_r)) begin
          next_s = DONE;
        end else begin
          next_s = DRAIN;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
    if (abort) begin
      next_s = IDLE;
    end else begin
      next_s = next_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Operand shift registers: the MSD sits at the top and is shifted out
  // one digit per array step. Zeros shift in, which supplies the 2'b00
  // digits needed for steps k >= N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sr_r <= '0;
      y_sr_r <= '0;
    end else if (abort) begin
      x_sr_r <= x_sr_r;
      y_sr_r <= y_sr_r;
    end else if ((state_r == IDLE) && start) begin
      x_sr_r <= norm_digits(x_in);
      y_sr_r <= norm_digits(y_in);
    end else if (step_s) begin
      x_sr_r <= {x_sr_r[2*N-3:0], 2'b00};
      y_sr_r <= {y_sr_r[2*N-3:0], 2'b00};
    end else begin
      x_sr_r <= x_sr_r;
      y_sr_r <= y_sr_r;
    end
  end

  // Step counter k: cleared in CLR, advanced on every unstalled step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r <= '0;
    end else if (abort) begin
      k_r <= '0;
    end else if (state_r == CLR) begin
      k_r <= '0;
    end else if (step_s) begin
      k_r <= k_r + KW'(1);
    end else begin
      k_r <= k_r;
    end
  end

  // Output buffer and digit counter. A capture in the same cycle as a
  // pop refills the buffer, so z_valid stays high and throughput is one
  // digit per cycle. Steps k < DELTA only fill the online pipeline and
  // their sel_dig is not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_dig_r   <= 2'b00;
      z_valid_r <= 1'b0;
      z_last_r  <= 1'b0;
      out_cnt_r <= '0;
    end else if (abort) begin
      z_dig_r   <= 2'b00;
      z_valid_r <= 1'b0;
      z_last_r  <= 1'b0;
      out_cnt_r <= '0;
    end else if (state_r == CLR) begin
      z_dig_r   <= z_dig_r;
      z_valid_r <= 1'b0;
      z_last_r  <= 1'b0;
      out_cnt_r <= '0;
    end else if (capture_s) begin
      z_dig_r   <= sel_dig;
      z_valid_r <= 1'b1;
      z_last_r  <= (k_r == K_LAST);
      out_cnt_r <= out_cnt_r + CW'(1);
    end else if (pop_s) begin
      z_dig_r   <= z_dig_r;
      z_valid_r <= 1'b0;
      z_last_r  <= 1'b0;
      out_cnt_r <= out_cnt_r;
    end else begin
      z_dig_r   <= z_dig_r;
      z_valid_r <= z_valid_r;
      z_last_r  <= z_last_r;
      out_cnt_r <= out_cnt_r;
    end
  end

  // Output decode. Everything here comes straight from the state register
  // or the registered buffer, except arr_en, which must react to z_ready
  // within the cycle to stall the array without losing a digit.
  always_comb begin
    busy    = (state_r != IDLE);
    arr_clr = (state_r == CLR);
    arr_en  = step_s;
    done    = (state_r == DONE);
    if (state_r == RUN) begin
      x_dig = x_sr_r[2*N-1 -: 2];
      y_dig = y_sr_r[2*N-1 -: 2];
    end else begin
      x_dig = 2'b00;
      y_dig = 2'b00;
    end
    z_dig   = z_dig_r;
    z_valid = z_valid_r;
    z_last  = z_last_r;
  end

endmodule

// File: tb/tb_online_mult_seq.sv
module tb_online_mult_seq;

  localparam int N  = 8;
  localparam int DL = 3;
  localparam int NC = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [15:0]  x_in;
  logic [15:0]  y_in;
  logic         busy;
  logic         arr_clr;
  logic         arr_en;
  logic [1:0]   x_dig;
  logic [1:0]   y_dig;
  logic [1:0]   sel_dig;
  logic [1:0]   z_dig;
  logic         z_valid;
  logic         z_ready;
  logic         z_last;
  logic         done;

  online_mult_seq #(.N(N), .DELTA(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_in(x_in), .y_in(y_in), .busy(busy), .arr_clr(arr_clr),
    .arr_en(arr_en), .x_dig(x_dig), .y_dig(y_dig), .sel_dig(sel_dig),
    .z_dig(z_dig), .z_valid(z_valid), .z_ready(z_ready),
    .z_last(z_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // per-cycle record of the last operation, index = cycle after start edge
  logic [1:0] rec_x [0:NC];
  logic [1:0] rec_y [0:NC];
  logic [1:0] rec_z [0:NC];
  logic       rec_en [0:NC];
  logic       rec_zv [0:NC];
  logic       rec_zl [0:NC];
  logic       rec_busy [0:NC];
  logic       rec_clr [0:NC];
  logic       rec_done [0:NC];
  logic [1:0] col_d [$];
  logic       col_l [$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          stall;     // z_ready low for this many cycles from cycle 6
    bit          stub;      // sel_dig = k mod 4 instead of 0
    int          start_at;  // extra start pulse while busy (0 = none)
    int          e_first;
    int          e_last;
    int          e_done;
    int          e_en;
    logic [15:0] e_z;       // collected digit j at [2j+1:2j]
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Start at the next edge (edge 0), then run ncyc cycles, recording
  // outputs at each negedge. Inputs change 1 time unit after posedge.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input int s_lo, input int s_hi, input bit stub,
                        input int start_at, input int abort_at, input int ncyc);
    int kc;
    kc = 0;
    col_d.delete();
    col_l.delete();
    for (int c = 0; c <= NC; c++) begin
      rec_x[c] = 2'b00; rec_y[c] = 2'b00; rec_z[c] = 2'b00;
      rec_en[c] = 1'b0; rec_zv[c] = 1'b0; rec_zl[c] = 1'b0;
      rec_busy[c] = 1'b0; rec_clr[c] = 1'b0; rec_done[c] = 1'b0;
    end
    @(posedge clk); #1;
    x_in = x; y_in = y; start = 1'b1; abort = 1'b0; z_ready = 1'b1; sel_dig = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      z_ready = !(c >= s_lo && c <= s_hi);
      sel_dig = stub ? 2'(kc) : 2'b00;
      start   = (c == start_at) || (c == abort_at);
      abort   = (c == abort_at);
      x_in    = (c == start_at) ? ~x : x;
      @(negedge clk);
      rec_x[c] = x_dig; rec_y[c] = y_dig; rec_z[c] = z_dig;
      rec_en[c] = arr_en; rec_zv[c] = z_valid; rec_zl[c] = z_last;
      rec_busy[c] = busy; rec_clr[c] = arr_clr; rec_done[c] = done;
      if (arr_en) kc++;
      if (z_valid && z_ready) begin
        col_d.push_back(z_dig);
        col_l.push_back(z_last);
      end
      if (c < ncyc) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int expk(input int c, input int l);
    if (c < DL + 3) return c - 2;
    else if (c < DL + 3 + l) return DL + 1;
    else return c - 2 - l;
  endfunction

  function automatic int first_of(input int which);
    for (int c = 1; c <= NC; c++) begin
      if (which == 0 && rec_zv[c]) return c;
      if (which == 1 && rec_zv[c] && rec_zl[c]) return c;
      if (which == 2 && rec_done[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_vec(input int vi, input vec_t v);
    int en_cnt;
    int terr;
    logic [15:0] zp;
    logic [7:0]  lp;
    en_cnt = 0;
    terr = 0;
    zp = '0;
    lp = '0;
    for (int c = 1; c <= NC; c++) if (rec_en[c]) en_cnt++;
    for (int j = 0; j < col_d.size() && j < 8; j++) begin
      zp[2*j +: 2] = col_d[j];
      lp[j] = col_l[j];
    end
    for (int c = 1; c <= 30; c++) begin
      bit run_e, en_e;
      int k;
      logic [1:0] xd, yd;
      run_e = (c >= 2) && (c <= N + DL + 1 + v.stall);
      en_e  = run_e && !(c >= DL + 3 && c < DL + 3 + v.stall);
      k     = expk(c, v.stall);
      xd    = (run_e && k < N) ? v.x[2*(N-1-k) +: 2] : 2'b00;
      yd    = (run_e && k < N) ? v.y[2*(N-1-k) +: 2] : 2'b00;
      if (rec_busy[c] !== (c <= v.e_done)) terr++;
      if (rec_clr[c]  !== (c == 1)) terr++;
      if (rec_done[c] !== (c == v.e_done)) terr++;
      if (rec_en[c]   !== en_e) terr++;
      if (rec_x[c]    !== xd) terr++;
      if (rec_y[c]    !== yd) terr++;
      if (c >= DL + 3 && c < DL + 3 + v.stall &&
          (rec_zv[c] !== 1'b1 || rec_z[c] !== v.e_z[1:0])) terr++;
    end
    chk($sformatf("v%0d first_valid", vi), first_of(0), v.e_first);
    chk($sformatf("v%0d last_cycle", vi), first_of(1), v.e_last);
    chk($sformatf("v%0d done_cycle", vi), first_of(2), v.e_done);
    chk($sformatf("v%0d arr_en_cnt", vi), en_cnt, v.e_en);
    chk($sformatf("v%0d digit_cnt", vi), col_d.size(), N);
    chk($sformatf("v%0d digits", vi), zp, v.e_z);
    chk($sformatf("v%0d last_flags", vi), lp, 8'h80);
    chk($sformatf("v%0d trace_errs", vi), terr, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    x_in = '0; y_in = '0; sel_dig = 2'b00; z_ready = 1'b1;

    //        x        y        stall stub st  first last done en  z
    vt[0] = '{16'h0000, 16'h0000, 0, 1'b0, 0, 6, 13, 14, 11, 16'h0000};
    vt[1] = '{16'h5555, 16'hAAAA, 0, 1'b1, 4, 6, 13, 14, 11, 16'h9393};
    vt[2] = '{16'h6189, 16'h5AA5, 4, 1'b1, 0, 6, 17, 18, 11, 16'h9393};
    vt[3] = '{16'h9999, 16'h0000, 2, 1'b1, 0, 6, 15, 16, 11, 16'h9393};

    #12;
    chk("reset_outputs",
        {busy, arr_clr, arr_en, x_dig, y_dig, z_dig, z_valid, z_last, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_op(vt[i].x, vt[i].y, DL + 3, DL + 2 + vt[i].stall, vt[i].stub,
             vt[i].start_at, 0, 30);
      check_vec(i, vt[i]);
    end

    // redundant 11 at the MSD is presented as 00
    run_op(16'hD555, 16'hAAAA, 0, -1, 1'b0, 0, 0, 20);
    chk("inv_msd_x", rec_x[2], 2'b00);
    chk("inv_next_x", rec_x[3], 2'b01);

    // abort (with a simultaneous start) at k=5, cycle 7
    run_op(16'h5555, 16'hAAAA, 0, -1, 1'b1, 0, 7, 10);
    chk("abort_pre_zv", rec_zv[7], 1'b1);
    chk("abort_busy", rec_busy[8], 1'b0);
    chk("abort_zv", rec_zv[8], 1'b0);
    chk("abort_en", rec_en[8], 1'b0);
    chk("abort_start_ign", {rec_busy[9], rec_busy[10], rec_clr[9]}, 3'b000);
    run_op(vt[0].x, vt[0].y, 0, -1, 1'b0, 0, 0, 30);
    check_vec(10, vt[0]);

    // async reset while waiting in DRAIN for the last handshake
    run_op(16'h6189, 16'h5AA5, 13, 40, 1'b1, 0, 0, 14);
    chk("drain_hold", {rec_busy[14], rec_zv[14], rec_zl[14], rec_z[14]}, 5'b11110);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        {busy, arr_clr, arr_en, x_dig, y_dig, z_dig, z_valid, z_last, done}, 32'h0);
    #1 rst = 1'b0;
    z_ready = 1'b1;
    run_op(vt[1].x, vt[1].y, 0, -1, 1'b1, 0, 0, 30);
    check_vec(11, vt[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
